// File: rtl/l1cache_nway_if.sv
// CPU-side and memory-side buses of the N-way L1 cache.
// master = environment (pipeline + physical memory), slave = cache.
interface l1cache_nway_if #(
   parameter int ADDR_W    = 16,
   parameter int LINE_BITS = 128
);
   logic [ADDR_W-1:0]    mem_address;
   logic                 mem_read;
   logic                 mem_write;
   logic [1:0]           mem_byte_enable;
   logic [15:0]          mem_wdata;
   logic [15:0]          mem_rdata;
   logic                 mem_resp;
   logic [ADDR_W-1:0]    pmem_address;
   logic                 pmem_read;
   logic                 pmem_write;
   logic [LINE_BITS-1:0] pmem_wdata;
   logic [LINE_BITS-1:0] pmem_rdata;
   logic                 pmem_resp;

   modport master (
      output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      input  mem_rdata, mem_resp,
      input  pmem_address, pmem_read, pmem_write, pmem_wdata,
      output pmem_rdata, pmem_resp
   );

   modport slave (
      input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
      output mem_rdata, mem_resp,
      output pmem_address, pmem_read, pmem_write, pmem_wdata,
      input  pmem_rdata, pmem_resp
   );
endinterface

// File: rtl/l1cache_nway.sv
// N-way write-back/write-allocate L1 cache with tree pseudo-LRU.
// Optional hit/miss counters: define L1CACHE_PERF_COUNTERS_EN.
module l1cache_nway #(
   parameter int WAYS      = 2,
   parameter int SETS      = 8,
   parameter int LINE_BITS = 128,
   parameter int ADDR_W    = 16
) (
   input  logic clk,
   input  logic reset,
   l1cache_nway_if.slave bus
`ifdef L1CACHE_PERF_COUNTERS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - 4 - IDX_W;
   localparam int WAY_W = $clog2(WAYS);
   localparam int PL_W  = WAYS - 1;

   typedef enum logic [1:0] {CHECK, WRITEBACK, ALLOCATE} state_t;
   state_t state_q, state_d;

   logic [LINE_BITS-1:0] data_q  [WAYS][SETS];
   logic [TAG_W-1:0]     tag_q   [WAYS][SETS];
   logic [WAYS-1:0]      valid_q [SETS];
   logic [WAYS-1:0]      dirty_q [SETS];
   logic [PL_W-1:0]      plru_q  [SETS];
   logic [WAY_W-1:0]     victim_q;

   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   logic [2:0]       word;
   logic             req, hit, inv;
   logic [WAY_W-1:0] hit_way, victim;
   logic [1:0]       hw2;
   logic [2:0]       pl_cur, pl_nxt;
   logic             hit_req, miss, wb_done, fill_done;

   assign idx  = bus.mem_address[4 +: IDX_W];
   assign tag  = bus.mem_address[ADDR_W-1 -: TAG_W];
   assign word = bus.mem_address[3:1];
   assign req  = bus.mem_read | bus.mem_write;
   assign hw2  = 2'(hit_way);

   assign hit_req   = (state_q == CHECK) && req && hit;
   assign miss      = (state_q == CHECK) && req && !hit;
   assign wb_done   = (state_q == WRITEBACK) && bus.pmem_resp;
   assign fill_done = (state_q == ALLOCATE) && bus.pmem_resp;

   // Lowest invalid way wins the victim slot; PLRU only when the set is full.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      inv     = 1'b0;
      victim  = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid_q[idx][w] && tag_q[w][idx] == tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid_q[idx][w]) begin
            inv    = 1'b1;
            victim = WAY_W'(w);
         end
      end
      pl_cur = '0;
      pl_cur[PL_W-1:0] = plru_q[idx];
      if (!inv) begin
         if (WAYS == 2)
            victim = WAY_W'(pl_cur[0]);
         else
            victim = WAY_W'(pl_cur[0] ? {1'b1, pl_cur[2]} : {1'b0, pl_cur[1]});
      end
   end

   always_comb begin
      pl_nxt = pl_cur;
      if (WAYS == 2) begin
         pl_nxt[0] = ~hw2[0];
      end else begin
         pl_nxt[0] = ~hw2[1];
         if (hw2[1]) pl_nxt[2] = ~hw2[0];
         else        pl_nxt[1] = ~hw2[0];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= CHECK;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         CHECK:
            if (miss)
               state_d = (valid_q[idx][victim] && dirty_q[idx][victim])
                       ? WRITEBACK : ALLOCATE;
         WRITEBACK: if (bus.pmem_resp) state_d = ALLOCATE;
         ALLOCATE:  if (bus.pmem_resp) state_d = CHECK;
         default:   state_d = CHECK;
      endcase
   end

   always_comb begin
      bus.mem_resp     = 1'b0;
      bus.pmem_read    = 1'b0;
      bus.pmem_write   = 1'b0;
      bus.pmem_address = '0;
      bus.pmem_wdata   = data_q[victim_q][idx];
      bus.mem_rdata    = data_q[hit_way][idx][{word, 4'b0000} +: 16];
      unique case (state_q)
         CHECK: bus.mem_resp = req && hit;
         WRITEBACK: begin
            bus.pmem_write   = 1'b1;
            bus.pmem_address = {tag_q[victim_q][idx], idx, 4'b0000};
         end
         ALLOCATE: begin
            bus.pmem_read    = 1'b1;
            bus.pmem_address = {tag, idx, 4'b0000};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
            plru_q[s]  <= '0;
         end
         victim_q <= '0;
      end else begin
         if (hit_req) begin
            plru_q[idx] <= pl_nxt[PL_W-1:0];
            if (bus.mem_write) dirty_q[idx][hit_way] <= 1'b1;
         end
         if (miss) victim_q <= victim;
         if (wb_done) dirty_q[idx][victim_q] <= 1'b0;
         if (fill_done) begin
            valid_q[idx][victim_q] <= 1'b1;
            dirty_q[idx][victim_q] <= 1'b0;
         end
      end
   end

   // Data and tags need no reset: valid bits gate every use.
   always_ff @(posedge clk) begin
      if (hit_req && bus.mem_write) begin
         if (bus.mem_byte_enable[0])
            data_q[hit_way][idx][{word, 4'b0000} +: 8] <= bus.mem_wdata[7:0];
         if (bus.mem_byte_enable[1])
            data_q[hit_way][idx][{word, 4'b1000} +: 8] <= bus.mem_wdata[15:8];
      end
      if (fill_done) begin
         data_q[victim_q][idx] <= bus.pmem_rdata;
         tag_q[victim_q][idx]  <= tag;
      end
   end

`ifdef L1CACHE_PERF_COUNTERS_EN
   logic missed_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_count  <= '0;
         miss_count <= '0;
         missed_q   <= 1'b0;
      end else begin
         if (miss) begin
            miss_count <= miss_count + 32'd1;
            missed_q   <= 1'b1;
         end
         if (hit_req) begin
            missed_q <= 1'b0;
            if (!missed_q) hit_count <= hit_count + 32'd1;
         end
      end
   end
`endif

   a_rw_excl: assert property (@(posedge clk) disable iff (reset)
      !(bus.mem_read && bus.mem_write));
endmodule

// File: tb/tb_l1cache_nway.sv
// Directed bench for l1cache_nway: a 2-way and a 4-way instance,
// each backed by its own fixed-latency line memory.
module tb_l1cache_nway;
   localparam int PER = 10;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;

   always #(PER / 2) clk = ~clk;

   l1cache_nway_if #(.ADDR_W(16), .LINE_BITS(128)) i2 ();
   l1cache_nway_if #(.ADDR_W(16), .LINE_BITS(128)) i4 ();

`ifdef L1CACHE_PERF_COUNTERS_EN
   logic [31:0] hc2, mc2, hc4, mc4;
`endif

   l1cache_nway #(.WAYS(2), .SETS(8), .LINE_BITS(128), .ADDR_W(16)) u2 (
      .clk(clk), .reset(reset), .bus(i2)
`ifdef L1CACHE_PERF_COUNTERS_EN
      , .hit_count(hc2), .miss_count(mc2)
`endif
   );

   l1cache_nway #(.WAYS(4), .SETS(8), .LINE_BITS(128), .ADDR_W(16)) u4 (
      .clk(clk), .reset(reset), .bus(i4)
`ifdef L1CACHE_PERF_COUNTERS_EN
      , .hit_count(hc4), .miss_count(mc4)
`endif
   );

   logic [127:0] mem0 [4096];
   logic [127:0] mem1 [4096];

   int           cnt0 = 0, wbn0 = 0, fln0 = 0;
   logic [15:0]  wba0, fla0;
   logic [127:0] wbd0;
   time          wbt0, flt0;
   bit           hold0 = 1'b0;

   int           cnt1 = 0, wbn1 = 0, fln1 = 0;
   logic [15:0]  wba1, fla1;

   // Memory side: responds three cycles after a request appears.
   always @(negedge clk) begin
      if (reset) begin
         cnt0 = 0;
         i2.pmem_resp = 1'b0;
         i2.pmem_rdata = '0;
      end else if (i2.pmem_resp) begin
         i2.pmem_resp = 1'b0;
      end else if ((i2.pmem_read || i2.pmem_write) && !hold0) begin
         cnt0++;
         if (cnt0 == 3) begin
            cnt0 = 0;
            if (i2.pmem_write) begin
               mem0[i2.pmem_address[15:4]] = i2.pmem_wdata;
               wbn0++;
               wba0 = i2.pmem_address;
               wbd0 = i2.pmem_wdata;
               wbt0 = $time;
            end else begin
               i2.pmem_rdata = mem0[i2.pmem_address[15:4]];
               fln0++;
               fla0 = i2.pmem_address;
               flt0 = $time;
            end
            i2.pmem_resp = 1'b1;
         end
      end else begin
         cnt0 = 0;
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         cnt1 = 0;
         i4.pmem_resp = 1'b0;
         i4.pmem_rdata = '0;
      end else if (i4.pmem_resp) begin
         i4.pmem_resp = 1'b0;
      end else if (i4.pmem_read || i4.pmem_write) begin
         cnt1++;
         if (cnt1 == 3) begin
            cnt1 = 0;
            if (i4.pmem_write) begin
               mem1[i4.pmem_address[15:4]] = i4.pmem_wdata;
               wbn1++;
               wba1 = i4.pmem_address;
            end else begin
               i4.pmem_rdata = mem1[i4.pmem_address[15:4]];
               fln1++;
               fla1 = i4.pmem_address;
            end
            i4.pmem_resp = 1'b1;
         end
      end else begin
         cnt1 = 0;
      end
   end

   task automatic drive(input int s, input logic [15:0] a, input logic rd,
                        input logic wr, input logic [1:0] be,
                        input logic [15:0] wd);
      if (s == 2) begin
         i2.mem_address = a; i2.mem_read = rd; i2.mem_write = wr;
         i2.mem_byte_enable = be; i2.mem_wdata = wd;
      end else begin
         i4.mem_address = a; i4.mem_read = rd; i4.mem_write = wr;
         i4.mem_byte_enable = be; i4.mem_wdata = wd;
      end
   endtask

   function automatic logic resp_of(input int s);
      return (s == 2) ? i2.mem_resp : i4.mem_resp;
   endfunction

   function automatic logic [15:0] rdata_of(input int s);
      return (s == 2) ? i2.mem_rdata : i4.mem_rdata;
   endfunction

   task automatic set_w(input int k, input logic [15:0] a, input logic [15:0] v);
      if (k == 0) mem0[a[15:4]][{a[3:1], 4'b0000} +: 16] = v;
      else        mem1[a[15:4]][{a[3:1], 4'b0000} +: 16] = v;
   endtask

   // One CPU request; cyc = cycles waited beyond the issue cycle.
   task automatic req(input int s, input logic [15:0] a, input logic wr,
                      input logic [1:0] be, input logic [15:0] wd,
                      output logic [15:0] rd, output int cyc, output time t);
      cyc = 0; rd = '0; t = 0;
      @(negedge clk);
      drive(s, a, !wr, wr, be, wd);
      #1;
      while (!resp_of(s) && cyc < 60) begin
         @(negedge clk); #1; cyc++;
      end
      if (!resp_of(s)) begin
         total++; bad++;
         $display("FAIL req_timeout addr=%h got no mem_resp", a);
      end else begin
         rd = rdata_of(s);
         t = $time;
      end
      @(posedge clk);
      #1 drive(s, 16'h0, 1'b0, 1'b0, 2'b11, 16'h0);
   endtask

   task automatic test_reset;
      reset = 1'b0;
      #1 reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      total++; if (i2.mem_resp !== 1'b0) begin bad++; $display("FAIL rst_resp2 got=%b exp=0", i2.mem_resp); end
      total++; if (i2.pmem_read !== 1'b0) begin bad++; $display("FAIL rst_pread2 got=%b exp=0", i2.pmem_read); end
      total++; if (i2.pmem_write !== 1'b0) begin bad++; $display("FAIL rst_pwrite2 got=%b exp=0", i2.pmem_write); end
      total++; if (i2.pmem_address !== 16'h0) begin bad++; $display("FAIL rst_paddr2 got=%h exp=0000", i2.pmem_address); end
      total++; if (i4.mem_resp !== 1'b0) begin bad++; $display("FAIL rst_resp4 got=%b exp=0", i4.mem_resp); end
      total++; if (i4.pmem_read !== 1'b0) begin bad++; $display("FAIL rst_pread4 got=%b exp=0", i4.pmem_read); end
      total++; if (i4.pmem_address !== 16'h0) begin bad++; $display("FAIL rst_paddr4 got=%h exp=0000", i4.pmem_address); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_cold_read;
      logic [15:0] rd; int cyc; time t; int w, f;
      set_w(0, 16'h1234, 16'hBEEF);
      w = wbn0; f = fln0;
      req(2, 16'h1234, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      total++; if (wbn0 !== w) begin bad++; $display("FAIL cold_nowb got=%0d exp=%0d", wbn0, w); end
      total++; if (fln0 !== f + 1) begin bad++; $display("FAIL cold_fill got=%0d exp=%0d", fln0, f + 1); end
      total++; if (fla0 !== 16'h1230) begin bad++; $display("FAIL cold_faddr got=%h exp=1230", fla0); end
      total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL cold_data got=%h exp=beef", rd); end
      total++; if (t - flt0 !== PER + 1) begin bad++; $display("FAIL cold_lat got=%0t exp=%0d", t - flt0, PER + 1); end
      req(2, 16'h1232, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      total++; if (cyc !== 0) begin bad++; $display("FAIL hit_wait got=%0d exp=0", cyc); end
      total++; if (rd !== 16'hC123) begin bad++; $display("FAIL hit_data got=%h exp=c123", rd); end
   endtask

   task automatic test_dirty_evict;
      logic [15:0] rd; int cyc; time t; int w, f;
      req(2, 16'h0010, 1'b1, 2'b11, 16'hA5A5, rd, cyc, t);
      req(2, 16'h0410, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      set_w(0, 16'h0810, 16'h5A01);
      w = wbn0; f = fln0;
      req(2, 16'h0810, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      total++; if (wbn0 !== w + 1) begin bad++; $display("FAIL evict_wb got=%0d exp=%0d", wbn0, w + 1); end
      total++; if (wba0 !== 16'h0010) begin bad++; $display("FAIL evict_waddr got=%h exp=0010", wba0); end
      total++; if (wbd0[15:0] !== 16'hA5A5) begin bad++; $display("FAIL evict_wdata got=%h exp=a5a5", wbd0[15:0]); end
      total++; if (fln0 !== f + 1) begin bad++; $display("FAIL evict_fill got=%0d exp=%0d", fln0, f + 1); end
      total++; if (fla0 !== 16'h0810) begin bad++; $display("FAIL evict_faddr got=%h exp=0810", fla0); end
      total++; if (!(flt0 > wbt0)) begin bad++; $display("FAIL evict_order got fill=%0t wb=%0t exp fill later", flt0, wbt0); end
      total++; if (rd !== 16'h5A01) begin bad++; $display("FAIL evict_data got=%h exp=5a01", rd); end
   endtask

   task automatic test_byte_write;
      logic [15:0] rd; int cyc; time t; int w;
      set_w(0, 16'h0010, 16'h1122);
      w = wbn0;
      req(2, 16'h0010, 1'b1, 2'b10, 16'hFF33, rd, cyc, t);
      req(2, 16'h0010, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      total++; if (rd !== 16'hFF22) begin bad++; $display("FAIL byte_hi got=%h exp=ff22", rd); end
      total++; if (wbn0 !== w) begin bad++; $display("FAIL byte_nowb got=%0d exp=%0d", wbn0, w); end
      req(2, 16'h0010, 1'b1, 2'b01, 16'h0044, rd, cyc, t);
      req(2, 16'h0010, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      total++; if (rd !== 16'hFF44) begin bad++; $display("FAIL byte_lo got=%h exp=ff44", rd); end
   endtask

   task automatic test_plru4;
      logic [15:0] rd; int cyc; time t; int w, f;
      for (int i = 1; i <= 4; i++)
         req(4, {4'(i), 12'h000}, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      req(4, 16'h1000, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      total++; if (cyc !== 0) begin bad++; $display("FAIL plru_touchA got=%0d exp=0", cyc); end
      w = wbn1; f = fln1;
      req(4, 16'h5000, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      total++; if (fln1 !== f + 1) begin bad++; $display("FAIL plru_fillE got=%0d exp=%0d", fln1, f + 1); end
      total++; if (fla1 !== 16'h5000) begin bad++; $display("FAIL plru_faddr got=%h exp=5000", fla1); end
      total++; if (wbn1 !== w) begin bad++; $display("FAIL plru_nowb got=%0d exp=%0d", wbn1, w); end
      req(4, 16'h1000, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      total++; if (cyc !== 0) begin bad++; $display("FAIL plru_keepA got=%0d exp=0", cyc); end
      req(4, 16'h2000, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      total++; if (cyc !== 0) begin bad++; $display("FAIL plru_keepB got=%0d exp=0", cyc); end
      f = fln1;
      req(4, 16'h3000, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      total++; if (fln1 !== f + 1) begin bad++; $display("FAIL plru_lostC got=%0d exp=%0d", fln1, f + 1); end
      total++; if (rd !== 16'hD300) begin bad++; $display("FAIL plru_dataC got=%h exp=d300", rd); end
   endtask

   task automatic test_reset_mid_wb;
      logic [15:0] rd; int cyc; time t; int w, f, n;
      req(2, 16'h0030, 1'b1, 2'b11, 16'h1234, rd, cyc, t);
      req(2, 16'h0430, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      hold0 = 1'b1;
      @(negedge clk);
      drive(2, 16'h0830, 1'b1, 1'b0, 2'b11, 16'h0);
      n = 0;
      while (!i2.pmem_write && n < 20) begin @(negedge clk); n++; end
      total++; if (i2.pmem_write !== 1'b1) begin bad++; $display("FAIL mid_wb_start got=%b exp=1", i2.pmem_write); end
      #2 reset = 1'b1;
      #1;
      total++; if (i2.pmem_write !== 1'b0) begin bad++; $display("FAIL mid_wb_drop got=%b exp=0", i2.pmem_write); end
      total++; if (i2.pmem_read !== 1'b0) begin bad++; $display("FAIL mid_rd_drop got=%b exp=0", i2.pmem_read); end
      drive(2, 16'h0, 1'b0, 1'b0, 2'b11, 16'h0);
      @(negedge clk);
      reset = 1'b0;
      hold0 = 1'b0;
      w = wbn0; f = fln0;
      req(2, 16'h0830, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      total++; if (wbn0 !== w) begin bad++; $display("FAIL post_rst_nowb got=%0d exp=%0d", wbn0, w); end
      total++; if (fln0 !== f + 1) begin bad++; $display("FAIL post_rst_miss got=%0d exp=%0d", fln0, f + 1); end
      req(2, 16'h0030, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      total++; if (wbn0 !== w) begin bad++; $display("FAIL post_rst_clean got=%0d exp=%0d", wbn0, w); end
      total++; if (rd !== 16'hC003) begin bad++; $display("FAIL post_rst_data got=%h exp=c003", rd); end
   endtask

`ifdef L1CACHE_PERF_COUNTERS_EN
   task automatic test_perf;
      logic [15:0] rd; int cyc; time t;
      req(4, 16'h7000, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      req(4, 16'h7000, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      req(4, 16'h7002, 1'b0, 2'b11, 16'h0, rd, cyc, t);
      req(4, 16'h7004, 1'b1, 2'b11, 16'h9999, rd, cyc, t);
      #1;
      total++; if (mc4 !== 32'd1) begin bad++; $display("FAIL perf_miss4 got=%0d exp=1", mc4); end
      total++; if (hc4 !== 32'd3) begin bad++; $display("FAIL perf_hit4 got=%0d exp=3", hc4); end
      total++; if (mc2 !== 32'd2) begin bad++; $display("FAIL perf_miss2 got=%0d exp=2", mc2); end
      total++; if (hc2 !== 32'd0) begin bad++; $display("FAIL perf_hit2 got=%0d exp=0", hc2); end
   endtask
`endif

   initial begin
      for (int i = 0; i < 4096; i++) begin
         mem0[i] = {8{4'hC, 12'(i)}};
         mem1[i] = {8{4'hD, 12'(i)}};
      end
      drive(2, 16'h0, 1'b0, 1'b0, 2'b11, 16'h0);
      drive(4, 16'h0, 1'b0, 1'b0, 2'b11, 16'h0);
      test_reset;
      test_cold_read;
      test_dirty_evict;
      test_byte_write;
      test_plru4;
      test_reset_mid_wb;
`ifdef L1CACHE_PERF_COUNTERS_EN
      test_perf;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
